dec_prf_freelist_ckpt_module: RTL and testbench

- Parametrised physical-register free list for the rename stage. It hands out up to ALLOC_W free PRF codes per cycle and accepts up to FREE_W released codes per cycle from commit.
- It keeps NUM_CKPT bitmap snapshots, taken at branch rename, so the free list can be restored in one cycle on a mispredict.
- It sits between decode/rename and the ROB commit/recovery logic.

---
 rtl/dec_prf_freelist_ckpt_module_if.sv | 41 ++++
 rtl/dec_prf_freelist_ckpt_module.sv | 166 ++++++++++++++++
 tb/tb_dec_prf_freelist_ckpt_module.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dec_prf_freelist_ckpt_module_if.sv
// Rename free-list bus: allocation lanes, commit release lanes, checkpoint
// take/drop/recovery controls and free-list status.
//   master : rename/commit/branch side, drives i_* and observes o_*
//   slave  : the free list, consumes i_* and drives o_*
interface dec_prf_freelist_ckpt_module_if #(
   parameter int unsigned NUM_PRF  = 128,
   parameter int unsigned ALLOC_W  = 4,
   parameter int unsigned FREE_W   = 4,
   parameter int unsigned NUM_CKPT = 4
);
   localparam int unsigned CW = $clog2(NUM_PRF);
   localparam int unsigned KW = $clog2(NUM_CKPT);

   logic [ALLOC_W-1:0]    i_fl_req;
   logic [ALLOC_W*CW-1:0] o_fl_prf_code;
   logic                  o_fl_stall;
   logic [FREE_W-1:0]     i_fl_wren;
   logic [FREE_W*CW-1:0]  i_fl_wr_prf_code;
   logic                  i_ckpt_take;
   logic [KW-1:0]         i_ckpt_take_id;
   logic                  i_ckpt_drop;
   logic [KW-1:0]         i_ckpt_drop_id;
   logic                  i_rcvy;
   logic [KW-1:0]         i_rcvy_id;
   logic [CW:0]           o_fl_count;
   logic                  o_fl_err;

   modport master (
      output i_fl_req, i_fl_wren, i_fl_wr_prf_code,
             i_ckpt_take, i_ckpt_take_id, i_ckpt_drop, i_ckpt_drop_id,
             i_rcvy, i_rcvy_id,
      input  o_fl_prf_code, o_fl_stall, o_fl_count, o_fl_err
   );

   modport slave (
      input  i_fl_req, i_fl_wren, i_fl_wr_prf_code,
             i_ckpt_take, i_ckpt_take_id, i_ckpt_drop, i_ckpt_drop_id,
             i_rcvy, i_rcvy_id,
      output o_fl_prf_code, o_fl_stall, o_fl_count, o_fl_err
   );
endinterface

// File: rtl/dec_prf_freelist_ckpt_module.sv
// Physical-register free list with branch checkpoints.
// Grants up to ALLOC_W free PRF codes per cycle (lowest index first, in lane
// order), accepts up to FREE_W released codes per cycle, and keeps NUM_CKPT
// bitmap snapshots for single-cycle mispredict recovery.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   fl         : free-list bus (slave modport), see the interface file
//     o_fl_prf_code / o_fl_stall are combinational from registered state
//     o_fl_count / o_fl_err are registered
module dec_prf_freelist_ckpt_module #(
   parameter int unsigned NUM_PRF  = 128,
   parameter int unsigned ALLOC_W  = 4,
   parameter int unsigned FREE_W   = 4,
   parameter int unsigned NUM_CKPT = 4
) (
   input logic                          clk,
   input logic                          rst_n,
   dec_prf_freelist_ckpt_module_if.slave fl
);
   localparam int unsigned CW = $clog2(NUM_PRF);
   localparam int unsigned KW = $clog2(NUM_CKPT);

   logic [NUM_PRF-1:0]    bitmap_q;
   logic [CW:0]           count_q;
   logic                  err_q;
   logic [NUM_PRF-1:0]    ckpt_q [NUM_CKPT];
   logic [NUM_CKPT-1:0]   ckpt_vld_q;

   logic [NUM_PRF-1:0]    avail;
   logic [NUM_PRF-1:0]    clr_mask;
   logic [NUM_PRF-1:0]    set_mask;
   logic [NUM_PRF-1:0]    bitmap_nxt;
   logic [ALLOC_W*CW-1:0] codes;
   logic [CW-1:0]         sel;
   logic                  found;
   logic [CW:0]           req_cnt;
   logic                  stall;
   logic [CW-1:0]         rel_code;
   logic                  rel_err;
   logic                  rcvy_ok;
   logic                  take_en;
   logic                  take_err;
   logic [NUM_CKPT-1:0]   take_hit;
   logic [NUM_CKPT-1:0]   vld_nxt;
   logic                  err_nxt;

   function automatic logic [CW:0] pop_prf(input logic [NUM_PRF-1:0] v);
      logic [CW:0] n;
      n = '0;
      for (int i = 0; i < int'(NUM_PRF); i++) n = n + (CW+1)'(v[i]);
      return n;
   endfunction

   // Lane-ordered allocation: each requesting lane takes the lowest remaining free bit.
   always_comb begin
      avail    = bitmap_q;
      clr_mask = '0;
      codes    = '0;
      sel      = '0;
      found    = 1'b0;
      req_cnt  = '0;
      for (int k = 0; k < int'(ALLOC_W); k++) begin
         sel   = '0;
         found = 1'b0;
         for (int i = int'(NUM_PRF) - 1; i >= 0; i--) begin
            if (avail[i]) begin
               sel   = CW'(i);
               found = 1'b1;
            end
         end
         req_cnt = req_cnt + (CW+1)'(fl.i_fl_req[k]);
         if (fl.i_fl_req[k] && found) begin
            codes[k*CW +: CW] = sel;
            avail[sel]        = 1'b0;
            clr_mask[sel]     = 1'b1;
         end
      end
   end

   assign stall = (count_q < req_cnt) | fl.i_rcvy;

   // Release mask and release-protocol errors. PRF 0 is kept out of the mask
   // so it can never become allocatable.
   always_comb begin
      set_mask = '0;
      rel_err  = 1'b0;
      rel_code = '0;
      for (int j = 0; j < int'(FREE_W); j++) begin
         rel_code = fl.i_fl_wr_prf_code[j*CW +: CW];
         if (fl.i_fl_wren[j]) begin
            if (rel_code == '0) begin
               rel_err = 1'b1;
            end else begin
               if (bitmap_q[rel_code]) rel_err = 1'b1;
               set_mask[rel_code] = 1'b1;
            end
            for (int m = j + 1; m < int'(FREE_W); m++) begin
               if (fl.i_fl_wren[m] && (fl.i_fl_wr_prf_code[m*CW +: CW] == rel_code))
                  rel_err = 1'b1;
            end
         end
      end
   end

   // Next bitmap, checkpoint valid bits and sticky error.
   always_comb begin
      rcvy_ok  = fl.i_rcvy & ckpt_vld_q[fl.i_rcvy_id];
      take_en  = fl.i_ckpt_take & ~fl.i_rcvy;
      take_hit = '0;
      for (int s = 0; s < int'(NUM_CKPT); s++)
         take_hit[s] = take_en && (fl.i_ckpt_take_id == KW'(s));

      if (rcvy_ok)
         bitmap_nxt = ckpt_q[fl.i_rcvy_id] | set_mask;
      else if (stall)
         bitmap_nxt = bitmap_q | set_mask;
      else
         bitmap_nxt = (bitmap_q | set_mask) & ~clr_mask;

      vld_nxt = ckpt_vld_q;
      if (fl.i_ckpt_drop) vld_nxt[fl.i_ckpt_drop_id] = 1'b0;
      if (rcvy_ok)        vld_nxt[fl.i_rcvy_id]      = 1'b0;
      if (take_en)        vld_nxt[fl.i_ckpt_take_id] = 1'b1;

      // A take into a slot dropped in the same cycle is a legal reuse.
      take_err = take_en & ckpt_vld_q[fl.i_ckpt_take_id]
               & ~(fl.i_ckpt_drop & (fl.i_ckpt_drop_id == fl.i_ckpt_take_id));
      err_nxt  = err_q | rel_err | take_err
               | (fl.i_ckpt_drop & ~ckpt_vld_q[fl.i_ckpt_drop_id])
               | (fl.i_rcvy & ~ckpt_vld_q[fl.i_rcvy_id]);
   end

   // Free-list state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bitmap_q   <= {{(NUM_PRF-1){1'b1}}, 1'b0};
         count_q    <= (CW+1)'(NUM_PRF - 1);
         err_q      <= 1'b0;
         ckpt_vld_q <= '0;
      end else begin
         bitmap_q   <= bitmap_nxt;
         count_q    <= pop_prf(bitmap_nxt);
         err_q      <= err_nxt;
         ckpt_vld_q <= vld_nxt;
      end
   end

   // Snapshots: written on take, otherwise live slots absorb later releases.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < int'(NUM_CKPT); s++) ckpt_q[s] <= '0;
      end else begin
         for (int s = 0; s < int'(NUM_CKPT); s++) begin
            if (take_hit[s])
               ckpt_q[s] <= bitmap_nxt;
            else if (ckpt_vld_q[s])
               ckpt_q[s] <= ckpt_q[s] | set_mask;
         end
      end
   end

   assign fl.o_fl_prf_code = codes;
   assign fl.o_fl_stall    = stall;
   assign fl.o_fl_count    = count_q;
   assign fl.o_fl_err      = err_q;
endmodule

// File: tb/tb_dec_prf_freelist_ckpt_module.sv
module tb_dec_prf_freelist_ckpt_module;
   localparam int unsigned NUM_PRF  = 128;
   localparam int unsigned ALLOC_W  = 4;
   localparam int unsigned FREE_W   = 4;
   localparam int unsigned NUM_CKPT = 4;
   localparam int unsigned CW       = 7;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   nchecks = 0;
   int   nerrors = 0;

   dec_prf_freelist_ckpt_module_if #(
      .NUM_PRF(NUM_PRF), .ALLOC_W(ALLOC_W), .FREE_W(FREE_W), .NUM_CKPT(NUM_CKPT)
   ) fl ();

   dec_prf_freelist_ckpt_module #(
      .NUM_PRF(NUM_PRF), .ALLOC_W(ALLOC_W), .FREE_W(FREE_W), .NUM_CKPT(NUM_CKPT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fl    (fl.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      fl.i_fl_req         = '0;
      fl.i_fl_wren        = '0;
      fl.i_fl_wr_prf_code = '0;
      fl.i_ckpt_take      = 1'b0;
      fl.i_ckpt_take_id   = '0;
      fl.i_ckpt_drop      = 1'b0;
      fl.i_ckpt_drop_id   = '0;
      fl.i_rcvy           = 1'b0;
      fl.i_rcvy_id        = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      nchecks++;
      if (fl.o_fl_count !== 8'd127) begin
         nerrors++; $display("FAIL reset_count: got %0d expected 127", fl.o_fl_count);
      end
      nchecks++;
      if (fl.o_fl_err !== 1'b0) begin
         nerrors++; $display("FAIL reset_err: got %0b expected 0", fl.o_fl_err);
      end
      nchecks++;
      if (fl.o_fl_stall !== 1'b0) begin
         nerrors++; $display("FAIL reset_stall: got %0b expected 0", fl.o_fl_stall);
      end
      nchecks++;
      if (fl.o_fl_prf_code !== '0) begin
         nerrors++; $display("FAIL reset_codes: got %h expected 0", fl.o_fl_prf_code);
      end
   endtask

   task automatic test_alloc_all();
      logic [CW-1:0] exp [4];
      exp = '{7'd1, 7'd2, 7'd3, 7'd4};
      do_reset();
      fl.i_fl_req = 4'b1111;
      #1;
      for (int k = 0; k < 4; k++) begin
         nchecks++;
         if (fl.o_fl_prf_code[k*CW +: CW] !== exp[k]) begin
            nerrors++;
            $display("FAIL alloc_all_lane%0d: got %0d expected %0d", k, fl.o_fl_prf_code[k*CW +: CW], exp[k]);
         end
      end
      nchecks++;
      if (fl.o_fl_stall !== 1'b0) begin
         nerrors++; $display("FAIL alloc_all_stall: got %0b expected 0", fl.o_fl_stall);
      end
      tick();
      fl.i_fl_req = '0;
      nchecks++;
      if (fl.o_fl_count !== 8'd123) begin
         nerrors++; $display("FAIL alloc_all_count: got %0d expected 123", fl.o_fl_count);
      end
   endtask

   task automatic test_sparse();
      logic [CW-1:0] exp [4];
      exp = '{7'd0, 7'd1, 7'd0, 7'd2};
      do_reset();
      fl.i_fl_req = 4'b1010;
      #1;
      for (int k = 0; k < 4; k++) begin
         nchecks++;
         if (fl.o_fl_prf_code[k*CW +: CW] !== exp[k]) begin
            nerrors++;
            $display("FAIL sparse_lane%0d: got %0d expected %0d", k, fl.o_fl_prf_code[k*CW +: CW], exp[k]);
         end
      end
      tick();
      fl.i_fl_req = '0;
      nchecks++;
      if (fl.o_fl_count !== 8'd125) begin
         nerrors++; $display("FAIL sparse_count: got %0d expected 125", fl.o_fl_count);
      end
   endtask

   task automatic test_stall_release();
      logic [CW-1:0] exp [4];
      exp = '{7'd10, 7'd11, 7'd126, 7'd0};
      do_reset();
      // 31 x 4 + 1 grants: codes 1..125 allocated, 126/127 left free.
      fl.i_fl_req = 4'b1111;
      repeat (31) tick();
      fl.i_fl_req = 4'b0001;
      tick();
      fl.i_fl_req = '0;
      nchecks++;
      if (fl.o_fl_count !== 8'd2) begin
         nerrors++; $display("FAIL drain_count: got %0d expected 2", fl.o_fl_count);
      end
      fl.i_fl_req                   = 4'b0111;
      fl.i_fl_wren                  = 4'b0011;
      fl.i_fl_wr_prf_code[0*CW +: CW] = 7'd10;
      fl.i_fl_wr_prf_code[1*CW +: CW] = 7'd11;
      #1;
      nchecks++;
      if (fl.o_fl_stall !== 1'b1) begin
         nerrors++; $display("FAIL empty_stall: got %0b expected 1", fl.o_fl_stall);
      end
      tick();
      fl.i_fl_wren        = '0;
      fl.i_fl_wr_prf_code = '0;
      #1;
      nchecks++;
      if (fl.o_fl_count !== 8'd4) begin
         nerrors++; $display("FAIL release_count: got %0d expected 4", fl.o_fl_count);
      end
      nchecks++;
      if (fl.o_fl_stall !== 1'b0) begin
         nerrors++; $display("FAIL regrant_stall: got %0b expected 0", fl.o_fl_stall);
      end
      for (int k = 0; k < 4; k++) begin
         nchecks++;
         if (fl.o_fl_prf_code[k*CW +: CW] !== exp[k]) begin
            nerrors++;
            $display("FAIL regrant_lane%0d: got %0d expected %0d", k, fl.o_fl_prf_code[k*CW +: CW], exp[k]);
         end
      end
      tick();
      fl.i_fl_req = '0;
      nchecks++;
      if (fl.o_fl_count !== 8'd1) begin
         nerrors++; $display("FAIL regrant_count: got %0d expected 1", fl.o_fl_count);
      end
      nchecks++;
      if (fl.o_fl_err !== 1'b0) begin
         nerrors++; $display("FAIL stall_err: got %0b expected 0", fl.o_fl_err);
      end
   endtask

   task automatic test_ckpt_recovery();
      logic [CW-1:0] exp [4];
      exp = '{7'd3, 7'd4, 7'd5, 7'd6};
      do_reset();
      fl.i_fl_req       = 4'b0011;
      fl.i_ckpt_take    = 1'b1;
      fl.i_ckpt_take_id = 2'd1;
      #1;
      nchecks++;
      if (fl.o_fl_prf_code[13:0] !== {7'd2, 7'd1}) begin
         nerrors++; $display("FAIL ckpt_grant12: got %h expected %h", fl.o_fl_prf_code[13:0], {7'd2, 7'd1});
      end
      tick();
      fl.i_ckpt_take = 1'b0;
      fl.i_fl_req    = 4'b1111;
      #1;
      for (int k = 0; k < 4; k++) begin
         nchecks++;
         if (fl.o_fl_prf_code[k*CW +: CW] !== exp[k]) begin
            nerrors++;
            $display("FAIL ckpt_grant_lane%0d: got %0d expected %0d", k, fl.o_fl_prf_code[k*CW +: CW], exp[k]);
         end
      end
      tick();
      fl.i_fl_req                     = '0;
      fl.i_fl_wren                    = 4'b0001;
      fl.i_fl_wr_prf_code[0*CW +: CW] = 7'd1;
      tick();
      fl.i_fl_wren        = '0;
      fl.i_fl_wr_prf_code = '0;
      nchecks++;
      if (fl.o_fl_count !== 8'd122) begin
         nerrors++; $display("FAIL pre_rcvy_count: got %0d expected 122", fl.o_fl_count);
      end
      fl.i_rcvy    = 1'b1;
      fl.i_rcvy_id = 2'd1;
      fl.i_fl_req  = 4'b1111;
      #1;
      nchecks++;
      if (fl.o_fl_stall !== 1'b1) begin
         nerrors++; $display("FAIL rcvy_stall: got %0b expected 1", fl.o_fl_stall);
      end
      tick();
      fl.i_rcvy   = 1'b0;
      fl.i_fl_req = 4'b0011;
      #1;
      nchecks++;
      if (fl.o_fl_count !== 8'd126) begin
         nerrors++; $display("FAIL rcvy_count: got %0d expected 126", fl.o_fl_count);
      end
      // Restored map: 1 free (released after snapshot), 2 held, 3.. free.
      nchecks++;
      if (fl.o_fl_prf_code[13:0] !== {7'd3, 7'd1}) begin
         nerrors++; $display("FAIL rcvy_grant: got %h expected %h", fl.o_fl_prf_code[13:0], {7'd3, 7'd1});
      end
      nchecks++;
      if (fl.o_fl_err !== 1'b0) begin
         nerrors++; $display("FAIL rcvy_err: got %0b expected 0", fl.o_fl_err);
      end
      tick();
      fl.i_fl_req = '0;
   endtask

   task automatic test_err_zero();
      do_reset();
      fl.i_fl_wren = 4'b0001;
      fl.i_fl_wr_prf_code = '0;
      tick();
      fl.i_fl_wren = '0;
      nchecks++;
      if (fl.o_fl_err !== 1'b1) begin
         nerrors++; $display("FAIL err_zero: got %0b expected 1", fl.o_fl_err);
      end
      repeat (3) tick();
      nchecks++;
      if (fl.o_fl_err !== 1'b1) begin
         nerrors++; $display("FAIL err_sticky: got %0b expected 1", fl.o_fl_err);
      end
   endtask

   task automatic test_err_dup();
      do_reset();
      fl.i_fl_req = 4'b1111;
      repeat (2) tick();
      fl.i_fl_req                     = '0;
      fl.i_fl_wren                    = 4'b0101;
      fl.i_fl_wr_prf_code[0*CW +: CW] = 7'd5;
      fl.i_fl_wr_prf_code[2*CW +: CW] = 7'd5;
      nchecks++;
      if (fl.o_fl_err !== 1'b0) begin
         nerrors++; $display("FAIL dup_pre_err: got %0b expected 0", fl.o_fl_err);
      end
      tick();
      fl.i_fl_wren        = '0;
      fl.i_fl_wr_prf_code = '0;
      nchecks++;
      if (fl.o_fl_err !== 1'b1) begin
         nerrors++; $display("FAIL dup_err: got %0b expected 1", fl.o_fl_err);
      end
      nchecks++;
      if (fl.o_fl_count !== 8'd120) begin
         nerrors++; $display("FAIL dup_count: got %0d expected 120", fl.o_fl_count);
      end
   endtask

   task automatic test_drop_invalid();
      do_reset();
      fl.i_ckpt_drop    = 1'b1;
      fl.i_ckpt_drop_id = 2'd3;
      tick();
      fl.i_ckpt_drop = 1'b0;
      nchecks++;
      if (fl.o_fl_err !== 1'b1) begin
         nerrors++; $display("FAIL drop_invalid_err: got %0b expected 1", fl.o_fl_err);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      fl.i_ckpt_take    = 1'b1;
      fl.i_ckpt_take_id = 2'd0;
      fl.i_fl_wren      = 4'b0001;
      fl.i_fl_wr_prf_code = '0;
      tick();
      fl.i_ckpt_take = 1'b0;
      fl.i_fl_wren   = '0;
      fl.i_fl_req    = 4'b1111;
      tick();
      nchecks++;
      if (fl.o_fl_count !== 8'd123 || fl.o_fl_err !== 1'b1) begin
         nerrors++; $display("FAIL pre_areset: got count %0d err %0b expected 123 1", fl.o_fl_count, fl.o_fl_err);
      end
      #2;
      rst_n = 1'b0;
      #1;
      nchecks++;
      if (fl.o_fl_count !== 8'd127) begin
         nerrors++; $display("FAIL areset_count: got %0d expected 127", fl.o_fl_count);
      end
      nchecks++;
      if (fl.o_fl_err !== 1'b0) begin
         nerrors++; $display("FAIL areset_err: got %0b expected 0", fl.o_fl_err);
      end
      nchecks++;
      if (fl.o_fl_prf_code[6:0] !== 7'd1) begin
         nerrors++; $display("FAIL areset_code: got %0d expected 1", fl.o_fl_prf_code[6:0]);
      end
      tick();
      fl.i_fl_req = '0;
      rst_n       = 1'b1;
      tick();
      fl.i_rcvy    = 1'b1;
      fl.i_rcvy_id = 2'd0;
      #1;
      nchecks++;
      if (fl.o_fl_stall !== 1'b1) begin
         nerrors++; $display("FAIL post_reset_rcvy_stall: got %0b expected 1", fl.o_fl_stall);
      end
      tick();
      fl.i_rcvy = 1'b0;
      nchecks++;
      if (fl.o_fl_err !== 1'b1) begin
         nerrors++; $display("FAIL post_reset_rcvy_err: got %0b expected 1", fl.o_fl_err);
      end
      nchecks++;
      if (fl.o_fl_count !== 8'd127) begin
         nerrors++; $display("FAIL post_reset_rcvy_count: got %0d expected 127", fl.o_fl_count);
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_alloc_all();
      test_sparse();
      test_stall_release();
      test_ckpt_recovery();
      test_err_zero();
      test_err_dup();
      test_drop_invalid();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end
endmodule
